// File: rtl/sram_access_controller.sv
// sram_access_controller
// Arbitrates the 68000 CPU and the DMA engine onto the 128 KB SRAM, registers
// the winning address/direction/byte strobes, decodes the 32 KB block select
// and times OE/WE with WAIT_STATES extra strobe cycles.
// Optional feature: define SRAM_RR_ARB_EN for round-robin arbitration between
// simultaneous requests; without it the CPU has fixed priority.
module sram_access_controller #(
   parameter int WAIT_STATES = 1,
   parameter int ADDR_W      = 17
) (
   input  logic              Clock,
   input  logic              Reset_L,
   input  logic              CpuReq_H,
   input  logic [ADDR_W-1:0] CpuAddress,
   input  logic              CpuRW,
   input  logic              CpuUDS_L,
   input  logic              CpuLDS_L,
   output logic              CpuDtAck_L,
   input  logic              DmaReq_H,
   input  logic [ADDR_W-1:0] DmaAddress,
   input  logic              DmaRW,
   output logic              DmaGrant_H,
   output logic              DmaDone_H,
   output logic [ADDR_W-1:0] SramAddress,
   output logic [3:0]        Block_H,
   output logic              SramOE_L,
   output logic              SramWE_L,
   output logic              SramUB_L,
   output logic              SramLB_L,
   output logic              DataSel_H
);

   typedef enum logic [1:0] {IDLE, SETUP, STROBE, ACK} state_t;

   state_t            state_reg, state_next;
   logic [ADDR_W-1:0] addr_reg, addr_next;
   logic              read_reg, read_next;
   logic              ub_reg, ub_next;       // latched active-low byte strobes
   logic              lb_reg, lb_next;
   logic              dma_reg, dma_next;     // 1 = current owner is the DMA
   logic              abort_reg, abort_next; // CPU dropped its request before ACK
   logic [3:0]        wait_cnt_reg, wait_cnt_next;
   logic              cpu_win, dma_win;

`ifdef SRAM_RR_ARB_EN
   logic              last_dma_reg, last_dma_next;

   // On a tie the master that did not win last time gets the SRAM
   assign cpu_win = CpuReq_H && (!DmaReq_H || last_dma_reg);
`else
   // Fixed CPU priority
   assign cpu_win = CpuReq_H;
`endif
   assign dma_win = DmaReq_H && !cpu_win;

   // State and latched-access registers; reset drops every strobe at once
   always_ff @(posedge Clock or negedge Reset_L) begin
      if (!Reset_L) begin
         state_reg    <= IDLE;
         addr_reg     <= '0;
         read_reg     <= 1'b1;
         ub_reg       <= 1'b1;
         lb_reg       <= 1'b1;
         dma_reg      <= 1'b0;
         abort_reg    <= 1'b0;
         wait_cnt_reg <= '0;
`ifdef SRAM_RR_ARB_EN
         last_dma_reg <= 1'b1;
`endif
      end else begin
         state_reg    <= state_next;
         addr_reg     <= addr_next;
         read_reg     <= read_next;
         ub_reg       <= ub_next;
         lb_reg       <= lb_next;
         dma_reg      <= dma_next;
         abort_reg    <= abort_next;
         wait_cnt_reg <= wait_cnt_next;
`ifdef SRAM_RR_ARB_EN
         last_dma_reg <= last_dma_next;
`endif
      end
   end

   // Next-state: grant in IDLE, one setup cycle, timed strobe, acknowledge
   always_comb begin
      state_next    = state_reg;
      addr_next     = addr_reg;
      read_next     = read_reg;
      ub_next       = ub_reg;
      lb_next       = lb_reg;
      dma_next      = dma_reg;
      abort_next    = abort_reg;
      wait_cnt_next = wait_cnt_reg;
`ifdef SRAM_RR_ARB_EN
      last_dma_next = last_dma_reg;
`endif
      case (state_reg)
         IDLE: begin
            if (cpu_win) begin
               addr_next  = CpuAddress;
               read_next  = CpuRW;
               ub_next    = CpuUDS_L;
               lb_next    = CpuLDS_L;
               dma_next   = 1'b0;
               abort_next = 1'b0;
               state_next = SETUP;
`ifdef SRAM_RR_ARB_EN
               last_dma_next = 1'b0;
`endif
            end else if (dma_win) begin
               addr_next  = DmaAddress;
               read_next  = DmaRW;
               ub_next    = 1'b0;
               lb_next    = 1'b0;
               dma_next   = 1'b1;
               abort_next = 1'b0;
               state_next = SETUP;
`ifdef SRAM_RR_ARB_EN
               last_dma_next = 1'b1;
`endif
            end
         end
         SETUP: begin
            wait_cnt_next = 4'(WAIT_STATES);
            if (!dma_reg && !CpuReq_H) abort_next = 1'b1;
            state_next = STROBE;
         end
         STROBE: begin
            if (!dma_reg && !CpuReq_H) abort_next = 1'b1;
            if (wait_cnt_reg == 4'd0) begin
               // An aborted CPU cycle finishes its strobe but skips ACK
               if (!dma_reg && (abort_reg || !CpuReq_H)) state_next = IDLE;
               else                                      state_next = ACK;
            end else begin
               wait_cnt_next = wait_cnt_reg - 4'd1;
            end
         end
         ACK: begin
            if (dma_reg || !CpuReq_H) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Moore outputs decoded from the state and the latched access
   always_comb begin
      SramAddress = addr_reg;
      DataSel_H   = dma_reg;
      Block_H     = (state_reg == IDLE) ? 4'b0000
                                        : (4'b0001 << addr_reg[ADDR_W-1 -: 2]);
      SramOE_L    = !((state_reg == STROBE) && read_reg);
      SramWE_L    = !((state_reg == STROBE) && !read_reg);
      SramUB_L    = (state_reg != STROBE) || ub_reg;
      SramLB_L    = (state_reg != STROBE) || lb_reg;
      CpuDtAck_L  = !((state_reg == ACK) && !dma_reg);
      DmaDone_H   = (state_reg == ACK) && dma_reg;
      DmaGrant_H  = (state_reg != IDLE) && dma_reg;
   end

endmodule

// File: doc/sram_access_controller.md
Name: sram_access_controller

Overview:
Sequences accesses to the 128 KB on-board SRAM, organised as four 32 KB blocks selected by address bits [16:15]. Two masters share the SRAM: the 68000 CPU, using an AS/DS/DtAck-style handshake, and a DMA engine, using a req/grant/done handshake. The block arbitrates between them, registers the address and access direction, decodes the block select, times the OE/WE strobes with programmable wait states, and returns the acknowledge to the winning master.

Parameters:
WAIT_STATES, 1, extra Clock cycles the strobe is held beyond the minimum one cycle; legal range 0..15.
ADDR_W, 17, SRAM byte-address width. Bits [ADDR_W-1:ADDR_W-2] select the block.

Ports:
Clock  in  1  system clock; all state changes on the rising edge
Reset_L  in  1  asynchronous, active-low reset
CpuReq_H  in  1  CPU SRAM cycle request (SRamSelect_H qualified by AS_L low); held until DtAck seen
CpuAddress  in  ADDR_W  CPU address
CpuRW  in  1  1 = read, 0 = write
CpuUDS_L  in  1  upper data strobe
CpuLDS_L  in  1  lower data strobe
CpuDtAck_L  out  1  data acknowledge to CPU
DmaReq_H  in  1  DMA request; level, held until DmaDone_H
DmaAddress  in  ADDR_W  DMA address (word access, both bytes)
DmaRW  in  1  1 = read, 0 = write
DmaGrant_H  out  1  DMA owns the SRAM
DmaDone_H  out  1  one-cycle completion pulse
SramAddress  out  ADDR_W  registered address to the SRAM
Block_H  out  4  one-hot block enable, decoded from SramAddress[ADDR_W-1:ADDR_W-2]
SramOE_L  out  1  output enable
SramWE_L  out  1  write enable
SramUB_L  out  1  upper byte enable
SramLB_L  out  1  lower byte enable
DataSel_H  out  1  data-path mux select: 1 = DMA, 0 = CPU

Behaviour:
- Reset (Reset_L low, asynchronous): state IDLE.
  - CpuDtAck_L = 1, SramOE_L = 1, SramWE_L = 1, SramUB_L = 1, SramLB_L = 1.
  - Block_H = 0, DmaGrant_H = 0, DmaDone_H = 0, DataSel_H = 0, SramAddress = 0, wait counter = 0.
  - Asserting reset mid-access drops every strobe immediately; no acknowledge is issued.
- FSM states: IDLE -> SETUP -> STROBE -> ACK -> IDLE.
- IDLE: sample requests each cycle.
  - If CpuReq_H is high, the CPU wins (fixed priority). Otherwise, if DmaReq_H is high, the DMA wins.
  - On a grant, latch the winner's address, RW, byte strobes (DMA: both low) and DataSel_H; go to SETUP.
  - If DMA wins, DmaGrant_H = 1 from SETUP through ACK.
- SETUP (1 cycle): SramAddress and Block_H valid; OE/WE still inactive. This is the address setup time.
- STROBE (WAIT_STATES+1 cycles):
  - Read: SramOE_L = 0. Write: SramWE_L = 0.
  - SramUB_L/SramLB_L follow the latched strobes.
  - The counter loads WAIT_STATES on entry and decrements each cycle; exit when it reaches 0.
- ACK: all strobes return to 1; Block_H and SramAddress are held (write hold time).
  - CPU owner: CpuDtAck_L = 0, held until CpuReq_H is sampled low, then IDLE with CpuDtAck_L = 1 on the same edge.
  - DMA owner: DmaDone_H = 1 for exactly one cycle, then IDLE with DmaGrant_H = 0.
- Block_H = 0 in IDLE. Exactly one bit is set in SETUP, STROBE and ACK.
- Latency: CPU read from CpuReq_H sampled high to CpuDtAck_L low = 3 + WAIT_STATES cycles.
- Back-to-back requests: each access returns to IDLE for at least 1 cycle (bus turnaround).
- A request arriving mid-access waits. The latched address is not affected by input changes after the grant.
- CpuReq_H falling before ACK (aborted cycle): the access completes normally, ACK is skipped, and the FSM returns to IDLE.
- Both byte strobes high on a CPU request: the access still runs with UB/LB inactive, so no bytes are transferred.

Optional Feature:
- Macro SRAM_RR_ARB_EN.
- Defined: round-robin arbitration. A 1-bit last-owner register (reset = DMA) gives a simultaneous request to the master that did not win last. A lone requester always wins.
- Undefined: fixed CPU priority; the DMA can be starved by continuous CPU traffic.

Test Plan:
- Reset release, no requests -> all strobes 1, Block_H = 0000, CpuDtAck_L = 1 for 10 cycles.
- CPU read, WAIT_STATES = 1, CpuAddress = 0x08000 -> Block_H = 0010 from SETUP; SramOE_L low for 2 cycles; CpuDtAck_L low 4 cycles after the request; CpuDtAck_L releases after CpuReq_H falls.
- CPU write, CpuAddress = 0x1FFFE, CpuUDS_L = 0, CpuLDS_L = 1 -> Block_H = 1000; SramWE_L low for WAIT_STATES+1 cycles; SramUB_L = 0, SramLB_L = 1.
- DMA write, DmaAddress = 0x10000 -> DmaGrant_H = 1, DataSel_H = 1, Block_H = 0100; DmaDone_H is a single-cycle pulse; DmaGrant_H = 0 in the next IDLE.
- CPU and DMA requesting in the same cycle, twice back-to-back -> CPU then CPU (macro off); CPU then DMA (SRAM_RR_ARB_EN defined).
- Reset_L pulsed low during STROBE of a write -> SramWE_L = 1 and Block_H = 0000 asynchronously; no CpuDtAck_L; the next request is serviced normally.
